// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-side memory controller behind the load/store unit.
// One request at a time over req/gnt/rvalid. Byte-lane writes go into an
// internal word array, and every access ends with a one-cycle rvalid_o pulse.
// Optional wait-state generator: define DMEM_WAIT_STATES_EN to insert
// WAIT_CYCLES wait states between grant and response. With the macro left
// undefined, the latency from grant to rvalid_o is always one cycle.
module data_mem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RESP = 2'd2;
`ifdef DMEM_WAIT_STATES_EN
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
`endif

  logic [1:0]    state;
  logic [31:0]   mem [DEPTH_WORDS];

  // Address decode on the live request
  logic [31:0]   offset_w;
  logic [31:0]   idx_w;
  logic          oor_w;
  logic          grant;

  // Request captured at grant; used when the access completes after wait states
  logic          we_p0;
  logic [3:0]    be_p0;
  logic [31:0]   wdata_p0;
  logic [AW-1:0] idx_p0;
  logic          oor_p0;

  // Operands of the access that commits on the edge entering RESP
  logic          acc_we;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_oor;
  logic          commit;

  // Underflow when addr_i < BASE_ADDR wraps to a huge index, so it is caught by
  // the depth compare as well as the explicit lower-bound test.
  assign offset_w = addr_i - BASE_ADDR;
  assign idx_w    = {2'b00, offset_w[31:2]};
  assign oor_w    = (addr_i < BASE_ADDR) || (idx_w >= DEPTH_LIM);

  // Grant only from IDLE and never while reset is asserted
  assign grant = (state == S_IDLE) && req_i && !reset;
  assign gnt_o = grant;

  // Without wait states the access happens on the grant edge, so use the live
  // inputs in IDLE and the captured request otherwise.
  assign acc_we    = (state == S_IDLE) ? we_i            : we_p0;
  assign acc_be    = (state == S_IDLE) ? be_i            : be_p0;
  assign acc_wdata = (state == S_IDLE) ? wdata_i         : wdata_p0;
  assign acc_idx   = (state == S_IDLE) ? idx_w[AW-1:0]   : idx_p0;
  assign acc_oor   = (state == S_IDLE) ? oor_w           : oor_p0;

`ifdef DMEM_WAIT_STATES_EN
  logic [3:0] wait_cnt;

  assign commit = !reset && ((grant && (WAIT_LD == 4'd0)) ||
                             ((state == S_WAIT) && (wait_cnt == 4'd1)));

  // Wait-state counter: loaded at grant, counts down to the response edge
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (grant) begin
      wait_cnt <= WAIT_LD;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = (WAIT_CYCLES != 0);
  assign commit = grant;
`endif

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^offset_w[1:0];

  // Control FSM: IDLE -> (WAIT) -> RESP -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
`ifdef DMEM_WAIT_STATES_EN
            state <= (WAIT_LD != 4'd0) ? S_WAIT : S_RESP;
`else
            state <= S_RESP;
`endif
          end
        end
`ifdef DMEM_WAIT_STATES_EN
        S_WAIT: begin
          if (wait_cnt == 4'd1) state <= S_RESP;
        end
`endif
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture the granted request; pure data, so no reset
  always_ff @(posedge clk) begin
    if (grant) begin
      we_p0    <= we_i;
      be_p0    <= be_i;
      wdata_p0 <= wdata_i;
      idx_p0   <= idx_w[AW-1:0];
      oor_p0   <= oor_w;
    end
  end

  // ---- stage boundary: access commit / response registers ----
  // Response outputs: rvalid pulse, read data and range error
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_o <= 1'b0;
      rdata_o  <= 32'd0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= commit;
      if (commit) begin
        err_o   <= acc_oor;
        rdata_o <= (!acc_we && !acc_oor) ? mem[acc_idx] : 32'd0;
      end else if (state == S_RESP) begin
        err_o   <= 1'b0;
      end
    end
  end

  // Byte-lane array write; commit already excludes reset
  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_oor) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_be[n]) mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
      end
    end
  end

endmodule
